mac_accum: RTL and testbench
============================

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 Parameter M, default 4: multiplier B-operand width; product width is P=M+N.
REQ-002 Parameter N, default 4: multiplier A-operand width.
REQ-003 Parameter K, default 4: number of products summed per result, K>=2.
REQ-004 Parameter ACC_W, default M+N+2: accumulator and result width, ACC_W>=P.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 sg  input  1  1 = product is two's-complement signed, 0 = unsigned.
REQ-008 clr  input  1  synchronous abort of the partial sum in progress.
REQ-009 in_valid  input  1  prod is valid this cycle.
REQ-010 in_ready  output  1  block accepts prod this cycle.
REQ-011 prod  input  P  product from the upstream multiplier stage.
REQ-012 out_valid  output  1  out_data/out_ovf hold a completed result.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 out_data  output  ACC_W  sum of K products.
REQ-015 out_ovf  output  1  sum overflowed ACC_W in the group's mode.

Function
REQ-016 Two states: ACC (collecting products) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 in ACC and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-018 Accept = in_valid & in_ready at a rising edge; no other input changes state in ACC.
REQ-019 Term counter cnt, 0..K-1, increments on each accept; it is 0 at group start.
REQ-020 Mode: sg is sampled on the accept with cnt==0 and held for the group; sg changes mid-group are ignored.
REQ-021 Extension: prod sign-extended to ACC_W in signed mode, zero-extended in unsigned mode.
REQ-022 On accept with cnt==0: acc <= ext(prod), ovf flag <= 0; otherwise acc <= acc + ext(prod), modulo 2^ACC_W.
REQ-023 Overflow: signed mode sets ovf when both addends share a sign and the sum's sign differs; unsigned mode sets ovf on carry-out of ACC_W; ovf is sticky within a group.
REQ-024 On accept with cnt==K-1: out_data <= final sum, out_ovf <= final ovf, cnt <= 0, state -> HOLD; out_valid rises the cycle after that edge.
REQ-025 Latency: out_valid asserts 1 cycle after the K-th accept; minimum K+1 cycles per result with back-to-back input; one-cycle bubble per result.
REQ-026 HOLD: out_data and out_ovf SHALL remain stable until out_valid & out_ready; then state -> ACC the next cycle.
REQ-027 clr in ACC: cnt <= 0, partial sum discarded; a simultaneous accept is discarded (clr wins).
REQ-028 clr in HOLD: no effect on held result or state.
REQ-029 in_valid low in ACC: cnt and acc hold; gaps between terms are allowed.
REQ-030 Output registers change only on the K-th accept or reset.

Reset
REQ-031 rst_n low at a clock edge: state <= ACC, cnt <= 0, acc <= 0, out_data <= 0, out_ovf <= 0, out_valid <= 0, latched mode <= 0.
REQ-032 Reset mid-group or in HOLD discards all partial and held data; rst_n overrides clr and all handshakes.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-034 Signed: sg=1, prods 0xF1,0x10,0x40,0xFF back-to-back, out_ready=1 -> out_valid 1 cycle after 4th accept, out_data=0x040, out_ovf=0.
REQ-035 Unsigned: sg=0, four prods 0xE1 -> out_data=0x384, out_ovf=0; sg toggled after first term -> same result.
REQ-036 Backpressure: result ready, out_ready=0 for 3 cycles -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> ACC next cycle, new group starts from 0.
REQ-037 clr: two terms 0x10 accepted, then clr with in_valid=1 prod=0x05 -> 0x05 dropped; next four prods 0x01 -> out_data=0x004.
REQ-038 Overflow (ACC_W=8, sg=0): prods 0xE1,0xE1,0x00,0x00 -> out_data=0xC2, out_ovf=1; the following group 4x0x01 -> out_ovf=0.
REQ-039 Reset: rst_n low after 2 accepts and again while in HOLD -> all outputs 0, in_ready=1 next cycle; following group sums from zero.

Source files
------------

// File: rtl/mac_accum.sv
// Accumulates K upstream products into one ACC_W-bit sum with overflow flag and
// presents it on a valid/ready output; the partial sum can be aborted with clr.
module mac_accum #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int ACC_W = M + N + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sg,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M+N-1:0]     prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_ovf
);

    localparam int P  = M + N;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt;
    logic [ACC_W-1:0]   acc;
    logic               ovf_q;
    logic               mode_q;

    logic               accept;
    logic               first;
    logic               mode_eff;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W:0]     sum;
    logic               step_ovf;
    logic [ACC_W-1:0]   new_acc;
    logic               new_ovf;

    assign accept   = in_valid & in_ready;
    assign first    = (cnt == '0);
    // The first term of a group decides the mode; later terms use the latched copy.
    assign mode_eff = first ? sg : mode_q;

    if (ACC_W > P) begin : g_ext
        assign ext = {{(ACC_W - P){mode_eff & prod[P-1]}}, prod};
    end else begin : g_noext
        assign ext = prod;
    end

    assign sum      = {1'b0, acc} + {1'b0, ext};
    assign step_ovf = mode_q ? ((acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                             : sum[ACC_W];
    assign new_acc  = first ? ext : sum[ACC_W-1:0];
    assign new_ovf  = first ? 1'b0 : (ovf_q | step_ovf);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (accept && !clr && (cnt == LAST)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ACC;
            cnt      <= '0;
            acc      <= '0;
            ovf_q    <= 1'b0;
            mode_q   <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state_q <= state_d;
            // clr only matters while collecting and beats a same-cycle accept.
            if (state_q == ACC && clr) begin
                cnt   <= '0;
                acc   <= '0;
                ovf_q <= 1'b0;
            end else if (accept) begin
                acc   <= new_acc;
                ovf_q <= new_ovf;
                if (first) begin
                    mode_q <= sg;
                end
                if (cnt == LAST) begin
                    cnt      <= '0;
                    out_data <= new_acc;
                    out_ovf  <= new_ovf;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: a default 10-bit instance and an 8-bit instance
// share the same stimulus so overflow at the narrow width can be observed.
module tb_mac_accum;

    logic       clk;
    logic       rst_n;
    logic       sg;
    logic       clr;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] prod;

    logic       a_in_ready;
    logic       a_out_valid;
    logic [9:0] a_out_data;
    logic       a_out_ovf;

    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    logic       b_out_ovf;

    int n_cmp;
    int n_err;

    mac_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sg        (sg),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .prod      (prod),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_ovf   (a_out_ovf)
    );

    mac_accum #(.ACC_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sg        (sg),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .prod      (prod),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic s,
                                 input logic c, input logic ordy);
        in_valid  = v;
        prod      = p;
        sg        = s;
        clr       = c;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        sg       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        prod     = 8'h00;
        out_ready = 1'b0;

        applyStimulus(0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'h1);
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(a_out_data), 32'h0);
        checkOutput("rst_out_ovf", 32'(a_out_ovf), 32'h0);
        rst_n = 1'b1;

        $display("[TB] signed group");
        applyStimulus(1, 8'hF1, 1, 0, 1);
        applyStimulus(1, 8'h10, 1, 0, 1);
        applyStimulus(1, 8'h40, 1, 0, 1);
        checkOutput("sgn_not_yet_valid", 32'(a_out_valid), 32'h0);
        applyStimulus(1, 8'hFF, 1, 0, 1);
        checkOutput("sgn_valid", 32'(a_out_valid), 32'h1);
        checkOutput("sgn_data", 32'(a_out_data), 32'h040);
        checkOutput("sgn_ovf", 32'(a_out_ovf), 32'h0);
        checkOutput("sgn_hold_not_ready", 32'(a_in_ready), 32'h0);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("sgn_drain_valid", 32'(a_out_valid), 32'h0);
        checkOutput("sgn_drain_ready", 32'(a_in_ready), 32'h1);

        $display("[TB] unsigned group with sg toggled mid-group");
        applyStimulus(1, 8'hE1, 0, 0, 0);
        applyStimulus(1, 8'hE1, 1, 0, 0);
        applyStimulus(1, 8'hE1, 1, 0, 0);
        applyStimulus(1, 8'hE1, 0, 0, 0);
        checkOutput("uns_valid", 32'(a_out_valid), 32'h1);
        checkOutput("uns_data", 32'(a_out_data), 32'h384);
        checkOutput("uns_ovf", 32'(a_out_ovf), 32'h0);

        $display("[TB] backpressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h7F, 1, (i == 1), 0);
            checkOutput("bp_valid", 32'(a_out_valid), 32'h1);
            checkOutput("bp_in_ready", 32'(a_in_ready), 32'h0);
            checkOutput("bp_data", 32'(a_out_data), 32'h384);
        end
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("bp_release_valid", 32'(a_out_valid), 32'h0);
        checkOutput("bp_release_ready", 32'(a_in_ready), 32'h1);
        checkOutput("bp_release_data", 32'(a_out_data), 32'h384);

        $display("[TB] clr drops partial sum");
        applyStimulus(1, 8'h10, 0, 0, 1);
        applyStimulus(1, 8'h10, 0, 0, 1);
        applyStimulus(1, 8'h05, 0, 1, 1);
        checkOutput("clr_in_ready", 32'(a_in_ready), 32'h1);
        applyStimulus(1, 8'h01, 0, 0, 1);
        applyStimulus(1, 8'h01, 0, 0, 1);
        applyStimulus(1, 8'h01, 0, 0, 1);
        checkOutput("clr_not_yet_valid", 32'(a_out_valid), 32'h0);
        applyStimulus(1, 8'h01, 0, 0, 1);
        checkOutput("clr_valid", 32'(a_out_valid), 32'h1);
        checkOutput("clr_data", 32'(a_out_data), 32'h004);
        applyStimulus(0, 8'h00, 0, 0, 1);

        $display("[TB] unsigned overflow at 8 bits");
        applyStimulus(1, 8'hE1, 0, 0, 1);
        applyStimulus(1, 8'hE1, 0, 0, 1);
        applyStimulus(1, 8'h00, 0, 0, 1);
        applyStimulus(1, 8'h00, 0, 0, 1);
        checkOutput("ovf10_data", 32'(a_out_data), 32'h1C2);
        checkOutput("ovf10_flag", 32'(a_out_ovf), 32'h0);
        checkOutput("ovf8_valid", 32'(b_out_valid), 32'h1);
        checkOutput("ovf8_data", 32'(b_out_data), 32'hC2);
        checkOutput("ovf8_flag", 32'(b_out_ovf), 32'h1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h01, 0, 0, 1);
        checkOutput("ovf8_next_data", 32'(b_out_data), 32'h04);
        checkOutput("ovf8_next_flag", 32'(b_out_ovf), 32'h0);
        applyStimulus(0, 8'h00, 0, 0, 1);

        $display("[TB] signed overflow at 8 bits");
        applyStimulus(1, 8'h7F, 1, 0, 1);
        applyStimulus(1, 8'h01, 1, 0, 1);
        applyStimulus(1, 8'h00, 1, 0, 1);
        applyStimulus(1, 8'h00, 1, 0, 1);
        checkOutput("sovf8_data", 32'(b_out_data), 32'h80);
        checkOutput("sovf8_flag", 32'(b_out_ovf), 32'h1);
        checkOutput("sovf10_data", 32'(a_out_data), 32'h080);
        checkOutput("sovf10_flag", 32'(a_out_ovf), 32'h0);
        applyStimulus(0, 8'h00, 0, 0, 1);

        $display("[TB] signed minimum with gaps");
        applyStimulus(1, 8'h80, 1, 0, 1);
        applyStimulus(0, 8'h33, 0, 0, 1);
        applyStimulus(1, 8'h80, 0, 0, 1);
        applyStimulus(0, 8'h33, 1, 0, 1);
        applyStimulus(0, 8'h33, 0, 0, 1);
        applyStimulus(1, 8'h80, 0, 0, 1);
        checkOutput("gap_not_yet_valid", 32'(a_out_valid), 32'h0);
        applyStimulus(1, 8'h80, 0, 0, 1);
        checkOutput("gap_valid", 32'(a_out_valid), 32'h1);
        checkOutput("gap_data", 32'(a_out_data), 32'h200);
        checkOutput("gap_ovf", 32'(a_out_ovf), 32'h0);
        checkOutput("gap8_data", 32'(b_out_data), 32'h00);
        checkOutput("gap8_ovf", 32'(b_out_ovf), 32'h1);
        applyStimulus(0, 8'h00, 0, 0, 1);

        $display("[TB] reset mid-group and in HOLD");
        applyStimulus(1, 8'h10, 0, 0, 1);
        applyStimulus(1, 8'h10, 0, 0, 1);
        rst_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 1);
        rst_n = 1'b1;
        checkOutput("rstmid_valid", 32'(a_out_valid), 32'h0);
        checkOutput("rstmid_data", 32'(a_out_data), 32'h0);
        checkOutput("rstmid_ovf8", 32'(b_out_ovf), 32'h0);
        checkOutput("rstmid_in_ready", 32'(a_in_ready), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h03, 0, 0, 0);
        checkOutput("rstmid_after_valid", 32'(a_out_valid), 32'h1);
        checkOutput("rstmid_after_data", 32'(a_out_data), 32'h00C);
        rst_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        checkOutput("rsthold_valid", 32'(a_out_valid), 32'h0);
        checkOutput("rsthold_data", 32'(a_out_data), 32'h0);
        checkOutput("rsthold_in_ready", 32'(a_in_ready), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h01, 0, 0, 1);
        checkOutput("rsthold_after_data", 32'(a_out_data), 32'h004);
        checkOutput("rsthold_after_ovf", 32'(a_out_ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
